// File: rtl/serial_sub10.sv
// rtl/serial_sub10.sv - bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell
module serial_sub10 #(
    parameter int WIDTH = 10,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dif,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             cell_d;
    logic             cell_b;
    logic [WIDTH-1:0] res_shift;
    logic             last_bit;

    assign cell_d    = op_a[0] ^ op_b[0] ^ brw;
    assign cell_b    = (~(op_a[0] ^ op_b[0]) & brw) | (~op_a[0] & op_b[0]);
    assign res_shift = {cell_d, res[WIDTH-1:1]};
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result outputs only move on the edge entering DONE, so they hold across the next operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            dif   <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        res   <= '0;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    res  <= res_shift;
                    op_a <= op_a >> 1;
                    op_b <= op_b >> 1;
                    brw  <= cell_b;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        dif  <= res_shift;
                        bout <= cell_b;
                        zero <= (res_shift == '0);
                        ovf  <= (a_msb ^ b_msb) & (a_msb ^ res_shift[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub10.sv
// tb/tb_serial_sub10.sv - directed scoreboard bench for serial_sub10
module tb_serial_sub10;

    localparam int WIDTH = 10;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dif;
    logic             bout;
    logic             zero;
    logic             ovf;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [WIDTH-1:0] dif;
        logic             bout;
        logic             zero;
        logic             ovf;
    } exp_t;

    exp_t sb[$];

    serial_sub10 #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dif   (dif),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        e.dif  = x - y;
        e.bout = (x < y);
        e.zero = (e.dif == '0);
        e.ovf  = (x[WIDTH-1] ^ y[WIDTH-1]) & (x[WIDTH-1] ^ e.dif[WIDTH-1]);
        return e;
    endfunction

    task automatic compare_result(input string tag);
        exp_t e;
        check({tag, " sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " dif"},  dif,  e.dif);
            check({tag, " bout"}, bout, e.bout);
            check({tag, " zero"}, zero, e.zero);
            check({tag, " ovf"},  ovf,  e.ovf);
        end
    endtask

    // Launch one operation and wait (bounded) for its done pulse; optionally hammer start/a/b meanwhile.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input bit interfere, input string tag);
        int lat = 0;
        int nbusy = 0;
        int extra = 0;
        bit got = 0;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back(model(x, y));
        @(posedge clk);
        #1;
        if (!interfere) start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                got = 1;
                lat = k;
            end
            if (interfere) begin
                start = 1'b1;
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end
            if (got) break;
        end
        check({tag, " latency"}, lat, WIDTH + 1);
        check({tag, " busy_cycles"}, nbusy, WIDTH);
        compare_result(tag);
        if (interfere) begin
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check({tag, " no_second_op"}, extra, 0);
        end
    endtask

    initial begin
        int ndone;
        int npulse;
        int last_cyc;
        int unstable;
        logic [WIDTH-1:0] held_exp;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dif",  dif,  0);
        check("reset bout", bout, 0);
        check("reset zero", zero, 0);
        check("reset ovf",  ovf,  0);
        rst = 1'b0;

        run_op(10'd5,   10'd3,   0, "5-3");
        run_op(10'd3,   10'd5,   0, "3-5");
        run_op(10'h2AB, 10'h2AB, 0, "equal");
        run_op(10'h200, 10'h001, 0, "ovf_neg");
        run_op(10'h1FF, 10'h3FF, 0, "ovf_pos");
        run_op(10'h123, 10'h045, 1, "interfere");

        // Abort in the 5th SHIFT cycle; the operation must vanish without a done pulse.
        @(negedge clk);
        a = 10'h155;
        b = 10'h0AA;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort dif",  dif,  0);
        check("abort bout", bout, 0);
        check("abort zero", zero, 0);
        check("abort ovf",  ovf,  0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort no_done", ndone, 0);
        run_op(10'd10, 10'd4, 0, "after_abort");

        // Start held high: operations every WIDTH+2 cycles, results stable while busy.
        @(negedge clk);
        a = 10'd7;
        b = 10'd9;
        start = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(model(10'd7, 10'd9));
        held_exp = 10'd6;
        npulse = 0;
        last_cyc = 0;
        unstable = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy && dif !== held_exp) unstable++;
            if (done) begin
                compare_result("b2b");
                if (npulse > 0) check("b2b interval", k - last_cyc, WIDTH + 2);
                last_cyc = k;
                held_exp = 10'h3FE;
                npulse++;
                if (npulse == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        check("b2b pulses", npulse, 3);
        check("b2b hold_while_busy", unstable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/serial_sub10.md
Name: serial_sub10

Overview:
- Bit-serial WIDTH-bit subtractor for the 10-bit CPU datapath.
- Computes A - B one bit per clock, LSB first, using a single full-subtractor cell (dif = a^b^br; bout = (~(a^b) & br) | (~a & b)) and a registered borrow.
- Sits between the operand register file and the ALU result/flag latch. It takes a start request, runs WIDTH cycles, then presents the difference, borrow and flags with a one-cycle done pulse.

Parameters:
- WIDTH, 10, operand and result width in bits (>= 2).
- CW, 4, iteration-counter width; must satisfy 2^CW >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result outputs valid from this cycle on.
- dif  output  WIDTH  registered result (a - b) mod 2^WIDTH.
- bout  output  1  final borrow; 1 means unsigned a < b.
- zero  output  1  dif == 0.
- ovf  output  1  signed (two's complement) overflow of a - b.

Behaviour:
- Reset: rst is sampled on the rising clk edge and overrides everything.
  - State goes to IDLE; busy, done, dif, bout, zero and ovf all become 0.
  - Internal shift registers, borrow and counter are cleared.
  - Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - Edge with start=1: load a into opA shift register and b into opB; clear borrow and counter; load zero into the result shift register; go to SHIFT.
  - Edge with start=0: stay in IDLE.
- SHIFT: busy=1, done=0. Each edge:
  - Full-subtract opA[0], opB[0] and borrow.
  - Shift the difference bit into the MSB of the result shift register.
  - Shift opA and opB right by 1.
  - Borrow takes the cell's bout.
  - Counter increments.
  - On the edge where counter == WIDTH-1 (the WIDTH-th bit), go to DONE and load the outputs:
    - dif = final result shift register contents.
    - bout = final borrow.
    - zero = (final dif == 0).
    - ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ dif[MSB]), using the latched operand MSBs.
- DONE:
  - done=1, busy=0 for exactly one cycle; next edge returns to IDLE unconditionally.
- start handling:
  - Ignored in SHIFT and DONE; not queued.
  - a and b changes after the accepting edge have no effect.
- Latency: start sampled at edge E0 → busy high during cycles E0..E0+WIDTH → done high for the cycle following edge E0+WIDTH (i.e. WIDTH+1 cycles after start).
- Throughput: one operation per WIDTH+2 cycles. Back-to-back requests are accepted on the first IDLE edge after DONE.
- Output hold: dif, bout, zero and ovf change only on the edge entering DONE, or on reset. They hold their values through IDLE and the whole of the next operation until its DONE.
- Arithmetic: unsigned wrap-around mod 2^WIDTH; no saturation. The borrow into bit 0 is always 0.

Test Plan:
- Reset, then start with a=5, b=3 → busy high 10 cycles; done 11 cycles after the start edge; dif=2, bout=0, zero=0, ovf=0.
- a=3, b=5 → dif=0x3FE (1022), bout=1, zero=0, ovf=0. Then a=0x2AB, b=0x2AB → dif=0, bout=0, zero=1, ovf=0.
- Signed overflow:
  - a=0x200 (-512), b=0x001 → dif=0x1FF, bout=0, ovf=1.
  - a=0x1FF (+511), b=0x3FF (-1) → dif=0x200, bout=1, ovf=1.
- Start re-asserted and a/b changed every cycle during SHIFT and during DONE → single done pulse, result matches the originally latched operands, no second operation.
- rst=1 for one cycle at the 5th SHIFT cycle → all outputs 0 next cycle, state IDLE, no done pulse. A fresh start with a=10, b=4 then yields dif=6.
- Back-to-back:
  - start held high continuously with a=7, b=9 → done pulses every 12 cycles; dif=0x3FE, bout=1.
  - Between pulses, previous results stay stable while busy=1.
